// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-cycle instruction decode stage with extended-immediate prefix support
// A-words with bit W-2 set (PREFIX_EN=1) load a pending high immediate instead of emitting output.
module decode_stage #(
    parameter int W         = 16,
    parameter int PREFIX_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_inst,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_ci,
    output logic           out_sm,
    output logic           out_err,
    output logic [5:0]     out_opc,
    output logic [2:0]     out_dst,
    output logic [2:0]     out_j,
    output logic [2*W-1:0] out_w
);

    logic           out_valid_q, out_valid_d;
    logic           ci_q, ci_d;
    logic           sm_q, sm_d;
    logic           err_q, err_d;
    logic [5:0]     opc_q, opc_d;
    logic [2:0]     dst_q, dst_d;
    logic [2:0]     j_q, j_d;
    logic [2*W-1:0] w_q, w_d;
    logic           pend_q, pend_d;
    logic [W-3:0]   pfx_q, pfx_d;

    logic           accept;
    logic           is_c;
    logic           is_pfx;
    logic [W-3:0]   pfx_sel;
    logic [2*W-1:0] w_imm;

    assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_c     = in_inst[W-1];
    assign is_pfx   = (PREFIX_EN != 0) && !is_c && in_inst[W-2];
    assign pfx_sel  = pend_q ? pfx_q : '0;

    always_comb begin
        w_imm = '0;
        if (PREFIX_EN != 0) begin
            w_imm[2*W-5:0] = {pfx_sel, in_inst[W-3:0]};
        end else begin
            w_imm[W-2:0] = in_inst[W-2:0];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ci_d        = ci_q;
        sm_d        = sm_q;
        err_d       = err_q;
        opc_d       = opc_q;
        dst_d       = dst_q;
        j_d         = j_q;
        w_d         = w_q;
        pend_d      = pend_q;
        pfx_d       = pfx_q;
        if (flush) begin
            out_valid_d = 1'b0;
            pend_d      = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept && is_pfx) begin
                pfx_d  = in_inst[W-3:0];
                pend_d = 1'b1;
            end else if (accept) begin
                out_valid_d = 1'b1;
                pend_d      = 1'b0;
                ci_d        = is_c;
                // A C-word arriving after a prefix is still emitted but marked as misuse
                err_d       = is_c && pend_q;
                if (is_c) begin
                    sm_d  = in_inst[12];
                    opc_d = in_inst[11:6];
                    dst_d = in_inst[5:3];
                    j_d   = in_inst[2:0];
                    w_d   = '0;
                end else begin
                    sm_d  = 1'b0;
                    opc_d = 6'd0;
                    dst_d = 3'b100;
                    j_d   = 3'd0;
                    w_d   = w_imm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ci_q        <= 1'b0;
            sm_q        <= 1'b0;
            err_q       <= 1'b0;
            opc_q       <= 6'd0;
            dst_q       <= 3'd0;
            j_q         <= 3'd0;
            w_q         <= '0;
            pend_q      <= 1'b0;
            pfx_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ci_q        <= ci_d;
            sm_q        <= sm_d;
            err_q       <= err_d;
            opc_q       <= opc_d;
            dst_q       <= dst_d;
            j_q         <= j_d;
            w_q         <= w_d;
            pend_q      <= pend_d;
            pfx_q       <= pfx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ci    = ci_q;
    assign out_sm    = sm_q;
    assign out_err   = err_q;
    assign out_opc   = opc_q;
    assign out_dst   = dst_q;
    assign out_j     = j_q;
    assign out_w     = w_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Parameters
REQ-001 SHALL have parameter W, default 16, giving the instruction word width; legal range 16..32.
REQ-002 SHALL have parameter PREFIX_EN, default 1; 1 enables extended-immediate prefix mode, 0 disables it.

Interface
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have flush  input  1  discard the output register and any pending prefix.
REQ-006 SHALL have in_valid  input  1  in_inst holds a word.
REQ-007 SHALL have in_ready  output  1  stage accepts a word this cycle.
REQ-008 SHALL have in_inst  input  W  raw instruction word.
REQ-009 SHALL have out_valid  output  1  decoded payload valid.
REQ-010 SHALL have out_ready  input  1  consumer takes the payload.
REQ-011 SHALL have out_ci, out_sm, out_err  output  1 each  compute-instruction flag, memory-operand select, prefix-misuse flag.
REQ-012 SHALL have out_opc  output  6  ALU opcode.
REQ-013 SHALL have out_dst  output  3  destination {A, D, *A}.
REQ-014 SHALL have out_j  output  3  jump condition.
REQ-015 SHALL have out_w  output  2*W  immediate value.

Function
REQ-016 Field map SHALL be: kind = bit W-1; sm = bit 12; opc = bits 11:6; dst = bits 5:3; j = bits 2:0; C-word bits W-2..13 are ignored.
REQ-017 kind=1 (C-instruction) SHALL produce ci=1, sm/opc/dst/j copied from fields, w=0.
REQ-018 kind=0 (A-instruction) SHALL produce ci=0, sm=0, opc=0, j=0, dst=3'b100, and w per REQ-019..020.
REQ-019 With PREFIX_EN=0, w SHALL be in_inst[W-2:0] zero-extended to 2*W.
REQ-020 With PREFIX_EN=1, bit W-2 of an A-word SHALL be the prefix flag; a non-prefix A-word SHALL give w = {pending prefix bits (W-2), in_inst[W-3:0]} zero-extended to 2*W, with the prefix bits 0 when no prefix is pending.
REQ-021 With PREFIX_EN=1, a prefix A-word SHALL be consumed without producing output; it stores in_inst[W-3:0] as the pending prefix and sets the pending flag.
REQ-022 Prefix followed by prefix SHALL overwrite the pending value without error.
REQ-023 A non-prefix A-word SHALL clear the pending flag on acceptance.
REQ-024 A C-word accepted while a prefix is pending SHALL be emitted normally with out_err=1 and SHALL clear the pending flag; out_err SHALL be 0 in every other case.
REQ-025 A word SHALL be accepted iff in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready and SHALL be 0 while flush or rst is high.
REQ-026 Latency SHALL be 1 cycle: a payload-producing word accepted at edge N SHALL show out_valid=1 with its payload after edge N.
REQ-027 out_valid with its payload SHALL remain stable until the cycle in which out_ready=1; back-to-back throughput SHALL be 1 word per cycle while out_ready=1.
REQ-028 An accepted prefix word with the output register drained SHALL leave out_valid=0 the next cycle.
REQ-029 flush SHALL, at the next edge, clear out_valid and the pending flag; flush SHALL take priority over acceptance, and no input is accepted that cycle.
REQ-030 Payload registers SHALL update only on acceptance of a payload-producing word.

Reset
REQ-031 rst SHALL, at the next edge, set out_valid=0, pending flag=0, prefix value=0, and all payload outputs to 0 (out_dst=3'b000).
REQ-032 rst asserted mid-transfer SHALL drop the held payload and pending prefix with no output; rst SHALL take priority over flush and input.

Verification
REQ-033 W=16, PREFIX_EN=0: in 0x7FFF -> out_ci=0, out_dst=3'b100, out_w=0x00007FFF one cycle later.
REQ-034 W=16, PREFIX_EN=1: prefix 0x6ABC, then A-word 0x1234 -> one output only, out_w = {0x2ABC, 0x1234 & 0x3FFF} = 0x0AAF1234; pending cleared afterwards.
REQ-035 W=16: C-word 0x9C10 (sm=1, opc=6'b110000, dst=3'b010, j=0) -> out_ci=1, out_sm=1, out_opc=6'b110000, out_dst=3'b010, out_j=0, out_w=0.
REQ-036 W=16, PREFIX_EN=1: prefix 0x4001 then C-word 0x8007 -> out_err=1, out_j=3'b111; next A-word 0x0005 -> out_w=0x00000005.
REQ-037 Stream 4 words with out_ready=0 for 3 cycles -> out payload held stable, in_ready=0 while held, no word lost or duplicated after release.
REQ-038 flush with a payload held and a prefix pending -> out_valid=0 and no prefix applied to the next A-word; rst mid-stream -> all outputs 0 after the next edge.
